// File: rtl/ray_dir_stream_gen_if.sv
// Ray stream bundle: valid/ready handshake plus per-beat direction,
// pixel coordinates and frame/line markers.
interface ray_dir_stream_gen_if #(
  parameter int OUT_W = 32,
  parameter int DIM_W = 13
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] ray_dir_x;
  logic signed [OUT_W-1:0] ray_dir_y;
  logic signed [OUT_W-1:0] ray_dir_z;
  logic [DIM_W-1:0]        pix_x;
  logic [DIM_W-1:0]        pix_y;
  logic                    sof;
  logic                    eol;
  logic                    eof;

  modport master (
    output out_valid, ray_dir_x, ray_dir_y, ray_dir_z,
    output pix_x, pix_y, sof, eol, eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, ray_dir_x, ray_dir_y, ray_dir_z,
    input  pix_x, pix_y, sof, eol, eof,
    output out_ready
  );
endinterface

// File: rtl/ray_dir_stream_gen.sv
// Raster-order primary-ray direction stream built by incremental add/sub.
// Optional RAYGEN_ABORT_EN adds abort input and aborted output.
module ray_dir_stream_gen #(
  parameter int VEC_W = 11,
  parameter int DIM_W = 13,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [VEC_W-1:0] cam_dir_x,
  input  logic signed [VEC_W-1:0] cam_dir_y,
  input  logic signed [VEC_W-1:0] cam_dir_z,
  input  logic signed [VEC_W-1:0] cam_right_x,
  input  logic signed [VEC_W-1:0] cam_right_y,
  input  logic signed [VEC_W-1:0] cam_right_z,
  input  logic signed [VEC_W-1:0] cam_up_x,
  input  logic signed [VEC_W-1:0] cam_up_y,
  input  logic signed [VEC_W-1:0] cam_up_z,
  input  logic [DIM_W-1:0]        image_width,
  input  logic [DIM_W-1:0]        image_height,
`ifdef RAYGEN_ABORT_EN
  input  logic                    abort,
  output logic                    aborted,
`endif
  output logic                    busy,
  output logic                    done,
  ray_dir_stream_gen_if.master    rays
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} state_t;

  function automatic logic signed [OUT_W-1:0] sx(
    input logic signed [VEC_W-1:0] v
  );
    return {{(OUT_W-VEC_W){v[VEC_W-1]}}, v};
  endfunction

  state_t state;
  logic signed [OUT_W-1:0] dx, dy, dz;
  logic signed [OUT_W-1:0] rx, ry, rz;
  logic signed [OUT_W-1:0] ux, uy, uz;
  logic signed [OUT_W-1:0] bx, by, bz;
  logic signed [OUT_W-1:0] ox, oy, oz;
  logic [DIM_W-1:0] w, h, px, py;
  logic valid;

  logic signed [OUT_W-1:0] hw, hh, ix, iy, iz;
  logic last_col, last_row, xfer, kill;

  // Half extents are the only multiplier operands; used in INIT alone.
  assign hw = {{(OUT_W-DIM_W+1){1'b0}}, w[DIM_W-1:1]};
  assign hh = {{(OUT_W-DIM_W+1){1'b0}}, h[DIM_W-1:1]};
  assign ix = dx - rx * hw + ux * hh;
  assign iy = dy - ry * hw + uy * hh;
  assign iz = dz - rz * hw + uz * hh;

  assign last_col = (px == w - DIM_W'(1));
  assign last_row = (py == h - DIM_W'(1));
  assign xfer     = valid & rays.out_ready;

`ifdef RAYGEN_ABORT_EN
  logic ab_flag;
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign rays.out_valid = valid;
  assign rays.ray_dir_x = ox;
  assign rays.ray_dir_y = oy;
  assign rays.ray_dir_z = oz;
  assign rays.pix_x     = px;
  assign rays.pix_y     = py;
  assign rays.sof       = valid & (px == '0) & (py == '0);
  assign rays.eol       = valid & last_col;
  assign rays.eof       = valid & last_col & last_row;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      {dx, dy, dz, rx, ry, rz} <= '0;
      {ux, uy, uz, bx, by, bz} <= '0;
      {ox, oy, oz} <= '0;
      {w, h, px, py} <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef RAYGEN_ABORT_EN
      ab_flag <= 1'b0;
      aborted <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RAYGEN_ABORT_EN
      aborted <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            dx <= sx(cam_dir_x);
            dy <= sx(cam_dir_y);
            dz <= sx(cam_dir_z);
            rx <= sx(cam_right_x);
            ry <= sx(cam_right_y);
            rz <= sx(cam_right_z);
            ux <= sx(cam_up_x);
            uy <= sx(cam_up_y);
            uz <= sx(cam_up_z);
            w  <= image_width;
            h  <= image_height;
            busy <= 1'b1;
            if (image_width == '0 || image_height == '0)
              state <= FIN;
            else
              state <= INIT;
          end
        end
        INIT: begin
          if (kill) begin
            state <= FIN;
`ifdef RAYGEN_ABORT_EN
            ab_flag <= 1'b1;
`endif
          end else begin
            {bx, by, bz} <= {ix, iy, iz};
            {ox, oy, oz} <= {ix, iy, iz};
            px    <= '0;
            py    <= '0;
            valid <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (xfer && last_col && last_row) begin
            valid <= 1'b0;
            state <= FIN;
          end else if (kill) begin
            valid <= 1'b0;
            state <= FIN;
`ifdef RAYGEN_ABORT_EN
            ab_flag <= 1'b1;
`endif
          end else if (xfer) begin
            if (!last_col) begin
              px <= px + DIM_W'(1);
              ox <= ox + rx;
              oy <= oy + ry;
              oz <= oz + rz;
            end else begin
              px <= '0;
              py <= py + DIM_W'(1);
              bx <= bx - ux;
              by <= by - uy;
              bz <= bz - uz;
              ox <= bx - ux;
              oy <= by - uy;
              oz <= bz - uz;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef RAYGEN_ABORT_EN
          aborted <= ab_flag;
          ab_flag <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dir_stream_gen.sv
// Directed bench for ray_dir_stream_gen: raster order, stalls, signed
// arithmetic, empty frames, mid-frame reset and ignored restarts.
module tb_ray_dir_stream_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic signed [10:0] cdx, cdy, cdz, crx, cry, crz, cux, cuy, cuz;
  logic [12:0] img_w, img_h;
  logic busy, done;
`ifdef RAYGEN_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  ray_dir_stream_gen_if #(.OUT_W(32), .DIM_W(13)) rif ();

  ray_dir_stream_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cam_dir_x(cdx), .cam_dir_y(cdy), .cam_dir_z(cdz),
    .cam_right_x(crx), .cam_right_y(cry), .cam_right_z(crz),
    .cam_up_x(cux), .cam_up_y(cuy), .cam_up_z(cuz),
    .image_width(img_w), .image_height(img_h),
`ifdef RAYGEN_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .rays(rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dir[3], rgt[3], upv[3];
  int lx[64], ly[64], lz[64];
  bit le[64];
  int nb, nd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_cam(input int d0, d1, d2, r0, r1, r2,
                         input int u0, u1, u2);
    dir[0] = d0; dir[1] = d1; dir[2] = d2;
    rgt[0] = r0; rgt[1] = r1; rgt[2] = r2;
    upv[0] = u0; upv[1] = u1; upv[2] = u2;
    cdx = 11'(d0); cdy = 11'(d1); cdz = 11'(d2);
    crx = 11'(r0); cry = 11'(r1); crz = 11'(r2);
    cux = 11'(u0); cuy = 11'(u1); cuz = 11'(u2);
  endtask

  task automatic run_frame(input int W, input int H, input bit toggle,
                           input bit poke, input int stop_at,
                           output int beats, output int ndone);
    int cyc, fin_idx, ex, ey, cx, cy;
    bit r, stalled;
    logic [31:0] p_rx, p_ry, p_rz;
    logic [12:0] p_px;
    logic p_eol;
    beats = 0; ndone = 0; fin_idx = -10; ex = 0; ey = 0;
    stalled = 0; cyc = 0;
    p_rx = '0; p_ry = '0; p_rz = '0; p_px = '0; p_eol = 1'b0;
    img_w = 13'(W); img_h = 13'(H);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("no_valid_in_init", 32'(rif.out_valid), 32'd0);
    step();
    chk("first_valid_latency", 32'(rif.out_valid), 32'd1);
    while (cyc < 600) begin
      r = toggle ? (cyc % 3 == 0) : 1'b1;
      start = 1'b0;
      if (rif.out_valid) begin
        if (stalled) begin
          chk("stall_ray_x", rif.ray_dir_x, p_rx);
          chk("stall_ray_y", rif.ray_dir_y, p_ry);
          chk("stall_ray_z", rif.ray_dir_z, p_rz);
          chk("stall_pix_x", 32'(rif.pix_x), 32'(p_px));
          chk("stall_eol", 32'(rif.eol), 32'(p_eol));
        end
        cx = ex - W / 2;
        cy = H / 2 - ey;
        chk("pix_x", 32'(rif.pix_x), 32'(ex));
        chk("pix_y", 32'(rif.pix_y), 32'(ey));
        chk("ray_x", rif.ray_dir_x, dir[0] + rgt[0]*cx + upv[0]*cy);
        chk("ray_y", rif.ray_dir_y, dir[1] + rgt[1]*cx + upv[1]*cy);
        chk("ray_z", rif.ray_dir_z, dir[2] + rgt[2]*cx + upv[2]*cy);
        chk("sof", 32'(rif.sof), 32'(ex == 0 && ey == 0));
        chk("eol", 32'(rif.eol), 32'(ex == W - 1));
        chk("eof", 32'(rif.eof), 32'(ex == W - 1 && ey == H - 1));
        if (beats < 64) begin
          lx[beats] = rif.ray_dir_x;
          ly[beats] = rif.ray_dir_y;
          lz[beats] = rif.ray_dir_z;
          le[beats] = rif.eol;
        end
        if (poke && beats == 5) start = 1'b1;
      end
      if (done) begin
        ndone++;
        chk("done_after_last", 32'(cyc - fin_idx), 32'd2);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        break;
      end
      rif.out_ready = r;
      stalled = rif.out_valid && !r;
      p_rx = rif.ray_dir_x; p_ry = rif.ray_dir_y; p_rz = rif.ray_dir_z;
      p_px = rif.pix_x; p_eol = rif.eol;
      if (rif.out_valid && r) begin
        if (ex == W - 1 && ey == H - 1) fin_idx = cyc;
        beats++;
        if (ex == W - 1) begin ex = 0; ey++; end
        else ex++;
      end
      step();
      cyc++;
      if (stop_at >= 0 && beats >= stop_at) break;
    end
    start = 1'b0;
    rif.out_ready = 1'b1;
    if (stop_at < 0) begin
      chk("frame_done_seen", 32'(ndone), 32'd1);
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_no_valid", 32'(rif.out_valid), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    rif.out_ready = 1'b1;
    img_w = '0; img_h = '0;
    set_cam(0, 0, 100, 1, 0, 0, 0, 1, 0);
    step(); step(); step();
    chk("rst_valid", 32'(rif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sof", 32'(rif.sof), 32'd0);
    chk("rst_eol", 32'(rif.eol), 32'd0);
    chk("rst_ray_z", rif.ray_dir_z, 32'd0);
    reset_n = 1'b1;
    step();

    // 4x2 frame, always ready
    run_frame(4, 2, 1'b0, 1'b0, -1, nb, nd);
    chk("f1_beats", 32'(nb), 32'd8);
    chk("f1_b0_x", lx[0], -32'sd2);
    chk("f1_b0_y", ly[0], 32'd1);
    chk("f1_b0_z", lz[0], 32'd100);
    chk("f1_b3_x", lx[3], 32'd1);
    chk("f1_b3_eol", 32'(le[3]), 32'd1);
    chk("f1_b2_eol", 32'(le[2]), 32'd0);
    chk("f1_b4_x", lx[4], -32'sd2);
    chk("f1_b4_y", ly[4], 32'd0);
    chk("f1_b7_x", lx[7], 32'd1);
    chk("f1_b7_z", lz[7], 32'd100);

    // same frame with ready 1,0,0,...
    run_frame(4, 2, 1'b1, 1'b0, -1, nb, nd);
    chk("f2_beats", 32'(nb), 32'd8);
    chk("f2_b5_x", lx[5], -32'sd1);
    chk("f2_b5_y", ly[5], 32'd0);

    // empty frame
    img_w = 13'd0; img_h = 13'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("w0_busy", 32'(busy), 32'd1);
    chk("w0_valid", 32'(rif.out_valid), 32'd0);
    chk("w0_done_early", 32'(done), 32'd0);
    step();
    chk("w0_done", 32'(done), 32'd1);
    chk("w0_busy_off", 32'(busy), 32'd0);
    chk("w0_valid2", 32'(rif.out_valid), 32'd0);
    step();
    chk("w0_done_pulse", 32'(done), 32'd0);

    // signed 3x3 frame with extreme dir components
    set_cam(-1024, 1023, 0, -2, 0, 1, 0, -3, 0);
    run_frame(3, 3, 1'b0, 1'b0, -1, nb, nd);
    chk("f3_beats", 32'(nb), 32'd9);
    chk("f3_b0_x", lx[0], -32'sd1022);
    chk("f3_b0_y", ly[0], 32'd1020);
    chk("f3_b0_z", lz[0], -32'sd1);
    chk("f3_b8_x", lx[8], -32'sd1026);
    chk("f3_b8_y", ly[8], 32'd1026);
    chk("f3_b8_z", lz[8], 32'd1);

    // reset at beat 3 of a 4x4 frame
    set_cam(0, 0, 100, 1, 0, 0, 0, 1, 0);
    run_frame(4, 4, 1'b0, 1'b0, 3, nb, nd);
    chk("rs_at_beat3", 32'(rif.pix_x), 32'd3);
    reset_n = 1'b0;
    step();
    chk("rs_valid", 32'(rif.out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_pix_x", 32'(rif.pix_x), 32'd0);
    chk("rs_ray_x", rif.ray_dir_x, 32'd0);
    chk("rs_eol", 32'(rif.eol), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    chk("rs_no_done", 32'(done), 32'd0);
    run_frame(4, 4, 1'b0, 1'b0, -1, nb, nd);
    chk("f4_beats", 32'(nb), 32'd16);

    // start pulsed mid-frame
    run_frame(4, 4, 1'b1, 1'b1, -1, nb, nd);
    chk("f5_beats", 32'(nb), 32'd16);
    chk("f5_dones", 32'(nd), 32'd1);
    step();
    chk("f5_no_restart", 32'(rif.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
